// File: rtl/mean_threshold_pkg.sv
// mean_threshold_pkg: FSM states and BMP row geometry shared by the mean_threshold slice.
package mean_threshold_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_GRAY = 3'd1,
      READ      = 3'd2,
      DRAIN     = 3'd3,
      DIVIDE    = 3'd4,
      DONE      = 3'd5
   } state_t;
   // BMP rows are padded to a multiple of 4 bytes
   function automatic int row_bytes(input int img_w);
      return (img_w * 3 + 3) / 4 * 4;
   endfunction
   function automatic int row_pad(input int img_w);
      return row_bytes(img_w) - img_w * 3;
   endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, WIDTH cycles after start.
module seq_divider #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             act_q, act_d;
   logic [WIDTH:0]   trial;
   logic             fits;
   always_comb begin
      trial = {rem_q, quo_q[WIDTH-1]};
      fits  = trial >= {1'b0, divisor};
      quo_d = quo_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      act_d = act_q;
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         cnt_d = CW'(WIDTH);
         act_d = 1'b1;
      end else if (cnt_q != '0) begin
         rem_d = fits ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], fits};
         cnt_d = cnt_q - 1'b1;
      end else begin
         act_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end
   assign quotient = quo_q;
   assign done     = act_q && (cnt_q == '0);
endmodule

// File: rtl/mean_threshold.sv
// mean_threshold: averages the gray image held in BMP RAM and presents the mean as a binarization threshold.
// Define MEAN_THRESHOLD_CLAMP_EN to clamp the threshold into [THR_MIN, THR_MAX].
module mean_threshold
   import mean_threshold_pkg::*;
#(
   parameter int BYTE_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 20,
   parameter int HEADER_SIZE = 54,
   parameter int IMG_W       = 512,
   parameter int IMG_H       = 512,
   parameter int SUM_WIDTH   = 26,
   parameter int THR_MIN     = 16,
   parameter int THR_MAX     = 240
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  gray_done,
   input  logic [BYTE_WIDTH-1:0] RAM_Q,
   output logic                  RAM_ren,
   output logic                  RAM_wen,
   output logic [BYTE_WIDTH-1:0] RAM_D,
   output logic [ADDR_WIDTH-1:0] RAM_addr,
   output logic [7:0]            threshold,
   output logic                  thr_valid,
   output logic                  busy
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = $clog2(IMG_W + 1);
   localparam int RW   = $clog2(IMG_H + 1);
   localparam logic [CW-1:0]         COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_H - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE0    = ADDR_WIDTH'(HEADER_SIZE);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(row_bytes(IMG_W));
   localparam logic [SUM_WIDTH-1:0]  DIVISOR  = SUM_WIDTH'(NPIX);
`ifdef MEAN_THRESHOLD_CLAMP_EN
   localparam logic [7:0] LO = 8'(THR_MIN);
   localparam logic [7:0] HI = 8'(THR_MAX);
`else
   localparam logic [7:0] LO = 8'd0;
   localparam logic [7:0] HI = 8'd255;
`endif
   if (SUM_WIDTH < 8 + $clog2(NPIX) || THR_MIN > THR_MAX) begin : g_cfg_err
      $error("mean_threshold: SUM_WIDTH too small for the image or THR_MIN > THR_MAX");
   end
   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
   logic [SUM_WIDTH-1:0]  sum_q, sum_d, quotient;
   logic [7:0]            thr_q, thr_d;
   logic                  vld_q, vld_d, gd_q, rd_q, div_done;
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      base_d  = base_q;
      sum_d   = rd_q ? sum_q + SUM_WIDTH'(RAM_Q) : sum_q;
      thr_d   = thr_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: if (in_valid) state_d = WAIT_GRAY;
         WAIT_GRAY: if (gd_q) begin
            state_d = READ;
            addr_d  = BASE0;
            base_d  = BASE0;
            col_d   = '0;
            row_d   = '0;
            sum_d   = '0;
         end
         READ: if (col_q == COL_LAST) begin
            // end of row: jump to the next row base, skipping the padding bytes
            col_d   = '0;
            row_d   = row_q + 1'b1;
            base_d  = base_q + ROW_STEP;
            addr_d  = row_q == ROW_LAST ? '0 : base_q + ROW_STEP;
            state_d = row_q == ROW_LAST ? DRAIN : READ;
         end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + ADDR_WIDTH'(3);
         end
         DRAIN: state_d = DIVIDE;
         DIVIDE: if (div_done) begin
            state_d = DONE;
            vld_d   = 1'b1;
            thr_d   = quotient < SUM_WIDTH'(LO) ? LO : quotient > SUM_WIDTH'(HI) ? HI : quotient[7:0];
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         base_q  <= '0;
         sum_q   <= '0;
         thr_q   <= '0;
         vld_q   <= 1'b0;
         gd_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         sum_q   <= sum_d;
         thr_q   <= thr_d;
         vld_q   <= vld_d;
         gd_q    <= gray_done;
         rd_q    <= RAM_ren;
      end
   end
   // dividend is taken from sum_d so the byte returned during DRAIN is included
   seq_divider #(.WIDTH(SUM_WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (state_q == DRAIN),
      .dividend (sum_d),
      .divisor  (DIVISOR),
      .quotient (quotient),
      .done     (div_done)
   );
   assign RAM_ren   = state_q == READ;
   assign RAM_wen   = 1'b0;
   assign RAM_D     = '0;
   assign RAM_addr  = addr_q;
   assign threshold = thr_q;
   assign thr_valid = vld_q;
   assign busy      = state_q inside {READ, DRAIN, DIVIDE};
endmodule

// File: tb/tb_mean_threshold.sv
// tb_mean_threshold: scoreboard bench running a 4x2 and a 3x2 (row-padded) instance side by side.
module tb_mean_threshold;
   typedef struct {int thr; int lat;} exp_t;
`ifdef MEAN_THRESHOLD_CLAMP_EN
   localparam int CL_A = 16, CL_B = 240;
`else
   localparam int CL_A = 5, CL_B = 250;
`endif
   localparam int LAT_A = 37, LAT_B = 35;
   logic clk = 0, rst, in_valid, gray_done;
   logic a_ren, a_wen, a_vld, a_busy, b_ren, b_wen, b_vld, b_busy;
   logic [7:0] a_q, a_d, a_thr, b_q, b_d, b_thr;
   logic [19:0] a_addr, b_addr;
   logic [7:0] mem_a [256], mem_b [256];
   int checks = 0, errors = 0;
   longint gd_time;
   int qa_addr[$], qb_addr[$];
   exp_t qa_thr[$], qb_thr[$];
   int ea [8] = '{54, 57, 60, 63, 66, 69, 72, 75};
   int eb [6] = '{54, 57, 60, 66, 69, 72};
   always #5 clk = ~clk;
   mean_threshold #(.IMG_W(4), .IMG_H(2)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .gray_done(gray_done), .RAM_Q(a_q),
      .RAM_ren(a_ren), .RAM_wen(a_wen), .RAM_D(a_d), .RAM_addr(a_addr),
      .threshold(a_thr), .thr_valid(a_vld), .busy(a_busy));
   mean_threshold #(.IMG_W(3), .IMG_H(2)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .gray_done(gray_done), .RAM_Q(b_q),
      .RAM_ren(b_ren), .RAM_wen(b_wen), .RAM_D(b_d), .RAM_addr(b_addr),
      .threshold(b_thr), .thr_valid(b_vld), .busy(b_busy));
   always @(posedge clk) begin
      if (a_ren) a_q <= mem_a[a_addr[7:0]];
      if (b_ren) b_q <= mem_b[b_addr[7:0]];
   end
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int lat_now();
      longint t = $time;
      return int'((t - gd_time - 5) / 10);
   endfunction
   logic a_vp = 0, b_vp = 0;
   always @(negedge clk) begin
      exp_t e;
      if (a_ren) begin
         if (qa_addr.size() == 0) check("addr_a unexpected read", int'(a_addr), -1);
         else check("addr_a", int'(a_addr), qa_addr.pop_front());
      end
      if (b_ren) begin
         if (qb_addr.size() == 0) check("addr_b unexpected read", int'(b_addr), -1);
         else check("addr_b", int'(b_addr), qb_addr.pop_front());
      end
      if (a_vld && !a_vp) begin
         if (qa_thr.size() == 0) check("thr_a unexpected valid", int'(a_thr), -1);
         else begin
            e = qa_thr.pop_front();
            check("thr_a", int'(a_thr), e.thr);
            check("lat_a", lat_now(), e.lat);
         end
      end
      if (b_vld && !b_vp) begin
         if (qb_thr.size() == 0) check("thr_b unexpected valid", int'(b_thr), -1);
         else begin
            e = qb_thr.pop_front();
            check("thr_b", int'(b_thr), e.thr);
            check("lat_b", lat_now(), e.lat);
         end
      end
      a_vp = a_vld;
      b_vp = b_vld;
      if (a_wen || b_wen || a_d != 0 || b_d != 0) check("ram write", int'({a_wen, b_wen, a_d, b_d}), 0);
   end
   task automatic load(input logic [7:0] pa [8], input logic [7:0] pb [6]);
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'hEE;
         mem_b[i] = 8'hEE;
      end
      for (int i = 0; i < 8; i++) mem_a[ea[i]] = pa[i];
      for (int i = 0; i < 6; i++) mem_b[eb[i]] = pb[i];
   endtask
   task automatic zero_chk(input string tag);
      check({tag, " ctl_a"}, int'({a_ren, a_vld, a_busy}), 0);
      check({tag, " addr_a"}, int'(a_addr), 0);
      check({tag, " thr_a"}, int'(a_thr), 0);
      check({tag, " ctl_b"}, int'({b_ren, b_vld, b_busy}), 0);
      check({tag, " addr_b"}, int'(b_addr), 0);
      check({tag, " thr_b"}, int'(b_thr), 0);
   endtask
   task automatic reset_pulse(input string tag);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      qa_addr.delete();
      qb_addr.delete();
      qa_thr.delete();
      qb_thr.delete();
      zero_chk(tag);
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic go(input int ta, input int tb_thr, input bit expect_done);
      for (int i = 0; i < 8; i++) qa_addr.push_back(ea[i]);
      for (int i = 0; i < 6; i++) qb_addr.push_back(eb[i]);
      if (expect_done) begin
         qa_thr.push_back('{ta, LAT_A});
         qb_thr.push_back('{tb_thr, LAT_B});
      end
      gray_done = 1;
      @(posedge clk);
      gd_time = $time;
      #1 gray_done = 0;
   endtask
   task automatic wait_done(input string tag);
      int n = 0;
      while (!(a_vld && b_vld) && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check({tag, " done"}, int'({a_vld, b_vld}), 3);
      @(negedge clk);
      #1;
      check({tag, " addr left"}, qa_addr.size() + qb_addr.size(), 0);
      check({tag, " thr left"}, qa_thr.size() + qb_thr.size(), 0);
   endtask
   initial begin
      rst = 1;
      in_valid = 0;
      gray_done = 0;
      load('{8{8'd100}}, '{6{8'd100}});
      repeat (3) @(posedge clk);
      #1 rst = 0;
      zero_chk("reset");
      gray_done = 1;
      @(posedge clk);
      #1 gray_done = 0;
      repeat (3) @(posedge clk);
      #1;
      check("idle pulse a", int'({a_busy, a_ren, a_vld}), 0);
      check("idle pulse b", int'({b_busy, b_ren, b_vld}), 0);
      in_valid = 1;
      repeat (4) @(posedge clk);
      #1;
      check("wait gray a", int'({a_busy, a_ren}), 0);
      check("wait gray b", int'({b_busy, b_ren}), 0);
      go(100, 100, 1);
      wait_done("run100");
      gray_done = 1;
      @(posedge clk);
      #1 gray_done = 0;
      repeat (10) @(posedge clk);
      #1;
      check("hold vld_a", int'(a_vld), 1);
      check("hold thr_a", int'(a_thr), 100);
      check("hold busy_a", int'(a_busy), 0);
      check("hold vld_b", int'(b_vld), 1);
      check("hold thr_b", int'(b_thr), 100);
      reset_pulse("rst2");
      load('{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255}, '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd61});
      go(127, 35, 1);
      wait_done("half");
      reset_pulse("rst3");
      load('{8{8'd200}}, '{6{8'd200}});
      go(0, 0, 0);
      repeat (4) @(posedge clk);
      #1 in_valid = 0;
      reset_pulse("abort");
      check("abort idle a", int'({a_busy, a_ren, a_vld}), 0);
      in_valid = 1;
      load('{8{8'd60}}, '{6{8'd70}});
      repeat (2) @(posedge clk);
      #1;
      go(60, 70, 1);
      wait_done("fresh");
      reset_pulse("rst4");
      load('{8{8'd5}}, '{6{8'd250}});
      go(CL_A, CL_B, 1);
      wait_done("clamp");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end
endmodule

// File: doc/mean_threshold.md
Name: mean_threshold

Overview:
- Adaptive-threshold stage between BGR2GRAY and BINARIZATION.
- After gray_done, reads every grayscale pixel back from the dual-port BMP RAM and accumulates their sum.
- Divides the sum by the pixel count and presents the mean gray level as threshold plus thr_valid.
- BINARIZATION consumes this value in place of a fixed constant.

Parameters:
- BYTE_WIDTH, 8: RAM data width.
- ADDR_WIDTH, 20: RAM address width.
- HEADER_SIZE, 54: byte offset of the first pixel.
- IMG_W, 512: image width in pixels.
- IMG_H, 512: image height in pixels.
- SUM_WIDTH, 26: accumulator width; must be at least 8 + ceil(log2(IMG_W*IMG_H)).
- THR_MIN, 16: lower clamp bound (used only with the optional feature).
- THR_MAX, 240: upper clamp bound (used only with the optional feature).

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: testbench run enable; level.
- gray_done, in, 1: BGR2GRAY has finished writing the gray image; level or pulse.
- RAM_Q, in, BYTE_WIDTH: RAM read data; valid 1 cycle after RAM_ren.
- RAM_ren, out, 1: RAM read enable.
- RAM_wen, out, 1: RAM write enable; constant 0.
- RAM_D, out, BYTE_WIDTH: RAM write data; constant 0.
- RAM_addr, out, ADDR_WIDTH: RAM address.
- threshold, out, 8: computed threshold.
- thr_valid, out, 1: threshold is valid; level.
- busy, out, 1: high in the READ, DRAIN and DIVIDE states.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State returns to IDLE.
  - All outputs go to 0: RAM_ren, RAM_addr, threshold, thr_valid, busy.
  - Accumulator, row/column counters and divider are cleared.
  - Reset asserted mid-operation aborts immediately; nothing is held over.
- Pixel addressing:
  - ROW_BYTES = IMG_W*3 rounded up to a multiple of 4 (BMP row padding).
  - Pixel (r,c) is read at address HEADER_SIZE + r*ROW_BYTES + c*3; only the B byte is read (gray is replicated across B, G and R).
  - The column pointer advances by 3 per pixel. At end of row it jumps to the next row base, skipping padding bytes.
- FSM:
  - IDLE -> WAIT_GRAY when in_valid=1.
  - WAIT_GRAY -> READ on the first cycle gray_done=1. gray_done is sampled, so a 1-cycle pulse suffices. If gray_done is already high when in_valid rises, READ is entered on the next cycle.
  - READ: RAM_ren=1 and one address per cycle, IMG_W*IMG_H cycles, row 0 first. The accumulator adds RAM_Q (zero-extended) in the cycle after each ren.
  - READ -> DRAIN after the last address is issued. DRAIN lasts 1 cycle with RAM_ren=0 and adds the final byte.
  - DRAIN -> DIVIDE. A restoring divider computes floor(sum / (IMG_W*IMG_H)) in exactly SUM_WIDTH cycles.
  - DIVIDE -> DONE. In DONE, threshold = quotient[7:0], thr_valid=1, busy=0.
  - DONE is held until rst. Further gray_done activity is ignored.
- Arithmetic:
  - No overflow is possible given the SUM_WIDTH rule.
  - The quotient is always ≤255; upper bits are discarded.
- Latency: gray_done sample to thr_valid = 1 + IMG_W*IMG_H + 1 + SUM_WIDTH + 1 cycles.
- The block never writes the RAM.
- While thr_valid=0, the downstream stage must not start; BINARIZATION gates on thr_valid.

Optional Feature:
- Macro: MEAN_THRESHOLD_CLAMP_EN.
- Defined: threshold = max(THR_MIN, min(THR_MAX, quotient)), registered together with thr_valid. This adds no latency.
- Undefined: threshold = raw quotient, and THR_MIN/THR_MAX are unused.

Decomposition:
- Into DEFINE.vh:
  - HEADER_SIZE
  - the derived ROW_BYTES / ROW_PAD computation macro
  - FSM state encodings (IDLE, WAIT_GRAY, READ, DRAIN, DIVIDE, DONE)
  - MEAN_THRESHOLD_CLAMP_EN
- Natural sub-module: seq_divider.
  - Parameter WIDTH.
  - Ports: start, dividend, divisor, quotient, done.
  - Restoring algorithm, 1 bit per cycle, WIDTH cycles; reusable by later stages.

Test Plan:
- IMG 4x2, all pixels 100 → addresses 54,57,60,63,66,69,72,75 in consecutive cycles; threshold=100; thr_valid high exactly 1+8+1+SUM_WIDTH+1 cycles after gray_done.
- IMG 3x2 (ROW_BYTES=12, pad 3) → address sequence 54,57,60,66,69,72; pad bytes are never read, checked via a RAM_addr monitor.
- IMG 4x2, pixels half 0 / half 255 → sum 1020, threshold=127 (floor).
- gray_done 1-cycle pulse arriving while still in IDLE (before in_valid) → ignored; later pulse after in_valid → normal run; a second gray_done pulse after DONE has no effect.
- rst=1 for 1 cycle midway through READ (pixel 4 of 8) → next cycle all outputs 0 and state IDLE; a fresh run gives the correct threshold with no stale sum.
- MEAN_THRESHOLD_CLAMP_EN defined, all pixels 5 → threshold=16; all pixels 250 → threshold=240; macro undefined → 5 and 250.
